// File: rtl/conv_encoder.sv
// conv_encoder
// Rate-1/2, constraint-length-3 convolutional encoder (G0 = 7 octal, G1 = 5 octal).
// Information bits are accepted with a valid/ready handshake. Code symbols are
// held on tx while seq_rdy is high until the decoder side acknowledges them
// with data_ack. Frames are FRAME_LEN information bits long.
//
// Optional feature macro: CONV_ENC_TAIL_EN
//   defined   : two zero tail bits are appended to each frame, so enc_state
//               returns to 00 at every frame end.
//   undefined : no tail. The shift register carries over between frames
//               (continuous stream) and is cleared only by rst.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   in_bit     : information bit
//   in_valid   : in_bit is valid
//   in_ready   : encoder takes in_bit this cycle
//   tx         : code symbol {G0 output, G1 output}, registered
//   seq_rdy    : tx holds a valid symbol, registered
//   data_ack   : downstream consumes tx this cycle
//   frame_done : one-cycle pulse after the final symbol of a frame is acknowledged
//   enc_state  : encoder shift register {u[n-1], u[n-2]}
module conv_encoder #(
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] tx,
    output logic       seq_rdy,
    input  logic       data_ack,
    output logic       frame_done,
    output logic [1:0] enc_state
);

`ifdef CONV_ENC_TAIL_EN
    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_TAIL = 2'd1,
        ST_WAIT = 2'd2
    } fsm_t;
`else
    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_WAIT = 2'd2
    } fsm_t;
`endif

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    // One trellis step: symbol for input u from state {a, b}.
    function automatic logic [1:0] encode_sym(input logic u, input logic [1:0] st);
        encode_sym = {u ^ st[1] ^ st[0], u ^ st[0]};
    endfunction

    fsm_t       fsm_r;
    logic [7:0] bit_cnt_r;
    logic [1:0] tx_r;
    logic       seq_rdy_r;
    logic       frame_done_r;
    logic [1:0] enc_state_r;
`ifdef CONV_ENC_TAIL_EN
    logic       tail_cnt_r;
`endif

    logic free_s;
    logic accept_s;
    logic tail_load_s;
    logic load_s;
    logic load_bit_s;
    logic retire_s;

    // Handshake decode: the single output slot is free when empty or being consumed.
    always_comb begin
        free_s   = 1'b0;
        accept_s = 1'b0;
        retire_s = 1'b0;
        if (!seq_rdy_r || data_ack) begin
            free_s = 1'b1;
        end else begin
            free_s = 1'b0;
        end
        if (fsm_r == ST_DATA) begin
            accept_s = in_valid && free_s;
        end else begin
            accept_s = 1'b0;
        end
        retire_s = seq_rdy_r && data_ack;
    end

    // Tail symbols (input forced to 0) are loaded whenever the slot frees up.
    always_comb begin
        tail_load_s = 1'b0;
`ifdef CONV_ENC_TAIL_EN
        if (fsm_r == ST_TAIL) begin
            tail_load_s = free_s;
        end else begin
            tail_load_s = 1'b0;
        end
`endif
        load_s = accept_s || tail_load_s;
        if (accept_s) begin
            load_bit_s = in_bit;
        end else begin
            load_bit_s = 1'b0;
        end
    end

    // Encoder datapath, output slot and frame-sequencing FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r        <= ST_DATA;
            bit_cnt_r    <= 8'd0;
            tx_r         <= 2'b00;
            seq_rdy_r    <= 1'b0;
            frame_done_r <= 1'b0;
            enc_state_r  <= 2'b00;
`ifdef CONV_ENC_TAIL_EN
            tail_cnt_r   <= 1'b0;
`endif
        end else begin
            frame_done_r <= 1'b0;

            // A load in the same cycle as an acknowledge replaces the symbol
            // without dropping seq_rdy, so there is no bubble.
            if (load_s) begin
                tx_r        <= encode_sym(load_bit_s, enc_state_r);
                seq_rdy_r   <= 1'b1;
                enc_state_r <= {load_bit_s, enc_state_r[1]};
            end else if (retire_s) begin
                seq_rdy_r   <= 1'b0;
            end

            case (fsm_r)
                ST_DATA: begin
                    if (accept_s) begin
                        bit_cnt_r <= bit_cnt_r + 8'd1;
                        if (bit_cnt_r == LAST_IDX) begin
`ifdef CONV_ENC_TAIL_EN
                            fsm_r      <= ST_TAIL;
                            tail_cnt_r <= 1'b0;
`else
                            fsm_r      <= ST_WAIT;
`endif
                        end
                    end
                end
`ifdef CONV_ENC_TAIL_EN
                ST_TAIL: begin
                    if (tail_load_s) begin
                        tail_cnt_r <= 1'b1;
                        if (tail_cnt_r) begin
                            fsm_r <= ST_WAIT;
                        end
                    end
                end
`endif
                ST_WAIT: begin
                    // Nothing is loaded here, so an acknowledge retires the final symbol.
                    if (retire_s) begin
                        frame_done_r <= 1'b1;
                        bit_cnt_r    <= 8'd0;
                        fsm_r        <= ST_DATA;
                    end
                end
                default: begin
                    fsm_r <= ST_DATA;
                end
            endcase
        end
    end

    assign in_ready   = accept_ok();
    assign tx         = tx_r;
    assign seq_rdy    = seq_rdy_r;
    assign frame_done = frame_done_r;
    assign enc_state  = enc_state_r;

    // in_ready is the DATA-state slot-free condition.
    function automatic logic accept_ok();
        accept_ok = (fsm_r == ST_DATA) && free_s;
    endfunction

endmodule
